// File: rtl/fc_neuron_scheduler.sv
// fc_neuron_scheduler
//   Sequences one fully-connected layer pass over pre-loaded data, weight and
//   bias RAMs. Each RUN cycle issues a pair of dual-port reads (data and
//   weight), the returned pair is multiplied and accumulated one cycle later,
//   and at the end of each neuron the bias is added, the result saturated
//   and offered on a valid/ready output.
//
// Ports
//   clk, nreset            clock, synchronous active-low reset
//   start                  begin a layer pass (sampled only in IDLE)
//   busy, done             busy while not IDLE; done pulses after last accept
//   re_data, addr_data_*   data RAM read enable / port A,B addresses
//   re_weight, addr_weight_* weight RAM read enable / port A,B addresses
//   re_bias, addr_bias     bias RAM read enable / address
//   rdata_*                RAM read data, valid one cycle after the read
//   out_data, out_index    saturated neuron result and its neuron index
//   out_valid, out_ready   result handshake
module fc_neuron_scheduler #(
  parameter  int DWIDTH = 16,
  parameter  int IN_LEN = 16,
  parameter  int OUT    = 10,
  parameter  int ACC_W  = 40,
  parameter  int FRAC   = 8,
  localparam int AW_D   = $clog2(IN_LEN),
  localparam int AW_W   = $clog2(IN_LEN * OUT),
  localparam int AW_B   = (OUT > 1) ? $clog2(OUT) : 1
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     re_data,
  output logic [AW_D-1:0]          addr_data_a,
  output logic [AW_D-1:0]          addr_data_b,
  output logic                     re_weight,
  output logic [AW_W-1:0]          addr_weight_a,
  output logic [AW_W-1:0]          addr_weight_b,
  output logic                     re_bias,
  output logic [AW_B-1:0]          addr_bias,
  input  logic signed [DWIDTH-1:0] rdata_data_a,
  input  logic signed [DWIDTH-1:0] rdata_data_b,
  input  logic signed [DWIDTH-1:0] rdata_weight_a,
  input  logic signed [DWIDTH-1:0] rdata_weight_b,
  input  logic signed [DWIDTH-1:0] rdata_bias,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [AW_B-1:0]          out_index,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int P  = IN_LEN / 2;
  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int PW = 2 * DWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAST,
    S_FINISH,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [AW_B-1:0] n_q, n_d;
  logic            acc_clr;
  logic            issue;
  logic            bias_issue;
  logic            done_d;

  logic [AW_D-1:0] addr_data_a_d, addr_data_b_d;
  logic [AW_W-1:0] addr_weight_a_d, addr_weight_b_d;
  int              wbase;

  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [DWIDTH-1:0] bias_p1;

  logic signed [PW-1:0]     prod_a, prod_b;
  logic signed [ACC_W-1:0]  pair_sum;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [ACC_W:0]    biased;

  // Clamp an ACC_W+1 bit value into the signed DWIDTH output range.
  function automatic logic signed [DWIDTH-1:0] sat_out(input logic signed [ACC_W:0] v);
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};
    if (v > MAXV)
      return {1'b0, {(DWIDTH-1){1'b1}}};
    else if (v < MINV)
      return {1'b1, {(DWIDTH-1){1'b0}}};
    else
      return v[DWIDTH-1:0];
  endfunction

  // Remove FRAC fraction bits (arithmetic) and add the sign-extended bias.
  function automatic logic signed [ACC_W:0] scale_bias(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DWIDTH-1:0] b);
    logic signed [ACC_W-1:0] sh;
    sh = a >>> FRAC;
    return {sh[ACC_W-1], sh} + {{(ACC_W+1-DWIDTH){b[DWIDTH-1]}}, b};
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    acc_clr    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (k_q == KW'(P - 1))
          state_d = S_LAST;
        else
          k_d = k_q + KW'(1);
      end
      S_LAST:   state_d = S_FINISH;
      S_FINISH: state_d = S_OUT;
      S_OUT: begin
        if (out_valid && out_ready) begin
          if (n_q == AW_B'(OUT - 1)) begin
            done_d  = 1'b1;
            n_d     = '0;
            state_d = S_IDLE;
          end else begin
            n_d     = n_q + AW_B'(1);
            k_d     = '0;
            acc_clr = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read requests are registered so they appear in the cycle the FSM is in RUN.
    issue      = (state_d == S_RUN);
    bias_issue = issue && (k_d == KW'(P - 1));

    wbase           = int'(n_d) * IN_LEN + 2 * int'(k_d);
    addr_data_a_d   = AW_D'(2 * int'(k_d));
    addr_data_b_d   = AW_D'(2 * int'(k_d) + 1);
    addr_weight_a_d = AW_W'(wbase);
    addr_weight_b_d = AW_W'(wbase + 1);
  end

  // Stage p0 -> p1: RAM data returned this cycle, form the pair of products.
  always_comb begin
    prod_a   = PW'(rdata_data_a) * PW'(rdata_weight_a);
    prod_b   = PW'(rdata_data_b) * PW'(rdata_weight_b);
    pair_sum = ACC_W'(prod_a) + ACC_W'(prod_b);
    acc_sh   = acc_p1;
    biased   = scale_bias(acc_sh, bias_p1);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      n_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      re_data       <= 1'b0;
      re_weight     <= 1'b0;
      re_bias       <= 1'b0;
      addr_data_a   <= '0;
      addr_data_b   <= AW_D'(1);
      addr_weight_a <= '0;
      addr_weight_b <= AW_W'(1);
      addr_bias     <= '0;
      vld_p1        <= 1'b0;
      acc_p1        <= '0;
      bias_p1       <= '0;
      out_data      <= '0;
      out_index     <= '0;
      out_valid     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      re_data   <= issue;
      re_weight <= issue;
      re_bias   <= bias_issue;
      if (issue) begin
        addr_data_a   <= addr_data_a_d;
        addr_data_b   <= addr_data_b_d;
        addr_weight_a <= addr_weight_a_d;
        addr_weight_b <= addr_weight_b_d;
      end
      if (bias_issue)
        addr_bias <= n_d;

      // Stage p1: read data is valid one cycle after the request.
      vld_p1 <= re_data;
      if (acc_clr)
        acc_p1 <= '0;
      else if (vld_p1)
        acc_p1 <= acc_p1 + pair_sum;
      if (state_q == S_LAST)
        bias_p1 <= rdata_bias;

      // Stage p2: scale, bias, saturate and hold until accepted.
      if (state_q == S_FINISH) begin
        out_data  <= sat_out(biased);
        out_index <= n_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_neuron_scheduler.sv
// tb_fc_neuron_scheduler
//   Directed bench for fc_neuron_scheduler with IN_LEN=4, OUT=2, FRAC=0.
//   Small RAM models with one-cycle read latency feed the DUT.
module tb_fc_neuron_scheduler;

  logic               clk = 1'b0;
  logic               nreset;
  logic               start;
  logic               busy, done;
  logic               re_data, re_weight, re_bias;
  logic [1:0]         addr_data_a, addr_data_b;
  logic [2:0]         addr_weight_a, addr_weight_b;
  logic [0:0]         addr_bias;
  logic signed [15:0] rd_da, rd_db, rd_wa, rd_wb, rd_b;
  logic signed [15:0] out_data;
  logic [0:0]         out_index;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        od_u;

  logic signed [15:0] dmem [4];
  logic signed [15:0] wmem [8];
  logic signed [15:0] bmem [2];

  int n_cmp = 0;
  int n_err = 0;

  assign od_u = out_data;

  always #5 clk = ~clk;

  fc_neuron_scheduler #(
    .DWIDTH(16), .IN_LEN(4), .OUT(2), .ACC_W(40), .FRAC(0)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start), .busy(busy), .done(done),
    .re_data(re_data), .addr_data_a(addr_data_a), .addr_data_b(addr_data_b),
    .re_weight(re_weight), .addr_weight_a(addr_weight_a), .addr_weight_b(addr_weight_b),
    .re_bias(re_bias), .addr_bias(addr_bias),
    .rdata_data_a(rd_da), .rdata_data_b(rd_db),
    .rdata_weight_a(rd_wa), .rdata_weight_b(rd_wb),
    .rdata_bias(rd_b),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready)
  );

  always @(posedge clk) begin
    if (re_data) begin
      rd_da <= dmem[addr_data_a];
      rd_db <= dmem[addr_data_b];
    end
    if (re_weight) begin
      rd_wa <= wmem[addr_weight_a];
      rd_wb <= wmem[addr_weight_b];
    end
    if (re_bias)
      rd_b <= bmem[addr_bias];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_re_data"}, re_data, 0);
    chk({pfx, "_re_weight"}, re_weight, 0);
    chk({pfx, "_re_bias"}, re_bias, 0);
    chk({pfx, "_ada"}, addr_data_a, 0);
    chk({pfx, "_adb"}, addr_data_b, 1);
    chk({pfx, "_awa"}, addr_weight_a, 0);
    chk({pfx, "_awb"}, addr_weight_b, 1);
    chk({pfx, "_abias"}, addr_bias, 0);
    chk({pfx, "_out_data"}, od_u, 0);
    chk({pfx, "_out_index"}, out_index, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int i = 0;
    while (!out_valid && i < lim) begin
      cyc();
      i++;
    end
    chk({tag, "_valid_wait"}, out_valid, 1);
  endtask

  task automatic load_basic();
    dmem = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    wmem = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, -16'sd1, 16'sd2, 16'sd0};
    bmem = '{16'sd5, -16'sd3};
  endtask

  // Full pass with out_ready high, cycle-exact against the start edge.
  // poke pulses start during RUN (cycle 1) and during OUT (cycle 5).
  task automatic run_basic(input string pfx, input bit poke);
    start = 1'b1;
    cyc();                                   // cycle 1
    start = poke;
    chk({pfx, "_c1_busy"}, busy, 1);
    chk({pfx, "_c1_re_data"}, re_data, 1);
    chk({pfx, "_c1_re_weight"}, re_weight, 1);
    chk({pfx, "_c1_re_bias"}, re_bias, 0);
    chk({pfx, "_c1_ada"}, addr_data_a, 0);
    chk({pfx, "_c1_adb"}, addr_data_b, 1);
    chk({pfx, "_c1_awa"}, addr_weight_a, 0);
    chk({pfx, "_c1_awb"}, addr_weight_b, 1);
    cyc();                                   // cycle 2
    start = 1'b0;
    chk({pfx, "_c2_re_data"}, re_data, 1);
    chk({pfx, "_c2_ada"}, addr_data_a, 2);
    chk({pfx, "_c2_adb"}, addr_data_b, 3);
    chk({pfx, "_c2_awa"}, addr_weight_a, 2);
    chk({pfx, "_c2_awb"}, addr_weight_b, 3);
    chk({pfx, "_c2_re_bias"}, re_bias, 1);
    chk({pfx, "_c2_abias"}, addr_bias, 0);
    cyc();                                   // cycle 3
    chk({pfx, "_c3_re_data"}, re_data, 0);
    chk({pfx, "_c3_re_bias"}, re_bias, 0);
    chk({pfx, "_c3_valid"}, out_valid, 0);
    cyc();                                   // cycle 4
    chk({pfx, "_c4_valid"}, out_valid, 0);
    cyc();                                   // cycle 5
    chk({pfx, "_c5_valid"}, out_valid, 1);
    chk({pfx, "_n0_data"}, od_u, 16'd15);
    chk({pfx, "_n0_index"}, out_index, 0);
    start = poke;
    cyc();                                   // cycle 6
    start = 1'b0;
    chk({pfx, "_c6_valid"}, out_valid, 0);
    chk({pfx, "_c6_re_data"}, re_data, 1);
    chk({pfx, "_c6_ada"}, addr_data_a, 0);
    chk({pfx, "_c6_awa"}, addr_weight_a, 4);
    chk({pfx, "_c6_awb"}, addr_weight_b, 5);
    chk({pfx, "_c6_done"}, done, 0);
    cyc();                                   // cycle 7
    chk({pfx, "_c7_adb"}, addr_data_b, 3);
    chk({pfx, "_c7_awa"}, addr_weight_a, 6);
    chk({pfx, "_c7_awb"}, addr_weight_b, 7);
    chk({pfx, "_c7_re_bias"}, re_bias, 1);
    chk({pfx, "_c7_abias"}, addr_bias, 1);
    cyc(); cyc(); cyc();                     // cycle 10
    chk({pfx, "_c10_valid"}, out_valid, 1);
    chk({pfx, "_n1_data"}, od_u, 16'd2);
    chk({pfx, "_n1_index"}, out_index, 1);
    chk({pfx, "_c10_busy"}, busy, 1);
    cyc();                                   // cycle 11
    chk({pfx, "_c11_done"}, done, 1);
    chk({pfx, "_c11_busy"}, busy, 0);
    chk({pfx, "_c11_valid"}, out_valid, 0);
    cyc();                                   // cycle 12
    chk({pfx, "_c12_done"}, done, 0);
    chk({pfx, "_c12_busy"}, busy, 0);
    chk({pfx, "_c12_re_data"}, re_data, 0);
  endtask

  task automatic run_sat(input string pfx, input logic [15:0] exp);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid({pfx, "_n0"}, 20);
    chk({pfx, "_n0_data"}, od_u, exp);
    cyc();
    wait_valid({pfx, "_n1"}, 20);
    chk({pfx, "_n1_data"}, od_u, exp);
    cyc();
    chk({pfx, "_done"}, done, 1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    rd_da = '0; rd_db = '0; rd_wa = '0; rd_wb = '0; rd_b = '0;
    load_basic();
    cyc(); cyc();
    check_reset("rst");
    nreset = 1'b1;
    cyc();
    check_reset("idle");

    run_basic("basic", 1'b0);
    run_basic("startbusy", 1'b1);

    // Backpressure on the first result.
    out_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid("bp_n0", 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", od_u, 16'd15);
      chk("bp_index", out_index, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_re_data", re_data, 0);
      chk("bp_re_weight", re_weight, 0);
      chk("bp_re_bias", re_bias, 0);
      chk("bp_ada", addr_data_a, 2);
      chk("bp_adb", addr_data_b, 3);
      chk("bp_awa", addr_weight_a, 2);
      chk("bp_awb", addr_weight_b, 3);
      chk("bp_abias", addr_bias, 0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_resume_re", re_data, 1);
    chk("bp_resume_awa", addr_weight_a, 4);
    chk("bp_resume_awb", addr_weight_b, 5);
    chk("bp_resume_valid", out_valid, 0);
    wait_valid("bp_n1", 10);
    chk("bp_n1_data", od_u, 16'd2);
    cyc();
    chk("bp_done", done, 1);
    cyc();

    // Reset during neuron 1 RUN.
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid("mr_n0", 10);
    cyc();
    chk("mr_in_run", re_data, 1);
    nreset = 1'b0;
    cyc();
    nreset = 1'b1;
    check_reset("midrst");
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("midrst_no_done", done, 0);
      chk("midrst_no_valid", out_valid, 0);
    end
    run_basic("afterrst", 1'b0);

    // Saturation, both directions.
    for (int i = 0; i < 4; i++) dmem[i] = 16'sh7FFF;
    for (int i = 0; i < 8; i++) wmem[i] = 16'sh7FFF;
    for (int i = 0; i < 2; i++) bmem[i] = 16'sh7FFF;
    run_sat("satpos", 16'h7FFF);
    for (int i = 0; i < 4; i++) dmem[i] = 16'sh8000;
    run_sat("satneg", 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_neuron_scheduler.md
Name: fc_neuron_scheduler

Overview:
- Sequences one fully-connected layer pass over pre-loaded data, weight and bias RAMs.
- Issues paired dual-port read addresses and accumulates two signed products per cycle.
- At the end of each output neuron, adds the bias, saturates, and presents the result on a valid/ready output.
- Sits between the RAM write/load control and the downstream result buffer or AXI read-back.

Parameters:
- DWIDTH, 16, signed data/weight/bias/result width
- IN_LEN, 16, input vector length in words; must be even and >= 4
- OUT, 10, number of output neurons
- ACC_W, 40, signed accumulator width
- FRAC, 8, fractional bits removed from the accumulator before the bias add
- Derived: AW_D = clog2(IN_LEN), AW_W = clog2(IN_LEN*OUT), AW_B = clog2(OUT); P = IN_LEN/2

Ports:
- clk  in  1  clock
- nreset  in  1  reset; synchronous, active-low
- start  in  1  begin a layer pass; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- re_data  out  1  data RAM read enable (both ports)
- addr_data_a / addr_data_b  out  AW_D  data RAM port A/B addresses
- re_weight  out  1  weight RAM read enable (both ports)
- addr_weight_a / addr_weight_b  out  AW_W  weight RAM port A/B addresses
- re_bias  out  1  bias RAM read enable
- addr_bias  out  AW_B  bias RAM address
- rdata_data_a / rdata_data_b  in  DWIDTH  data RAM read data
- rdata_weight_a / rdata_weight_b  in  DWIDTH  weight RAM read data
- rdata_bias  in  DWIDTH  bias RAM read data
- out_data  out  DWIDTH  saturated neuron result
- out_index  out  AW_B  index of the neuron on out_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result

Behaviour:
- Reset (nreset low at clk edge): state IDLE.
  - All outputs 0, except addr_data_b = 1 and addr_weight_b = 1.
  - Accumulator and neuron counter n cleared.
- Reset mid-operation aborts immediately with the same values. No partial result is emitted.
- RAM read latency is fixed at 1 cycle: data is valid the cycle after re/address.
- Registers: pair counter k (0..P-1), neuron counter n (0..OUT-1).
- IDLE:
  - start = 1 -> RUN, with k = 0 and acc = 0.
  - start is ignored in every other state.
- RUN (P cycles):
  - re_data = re_weight = 1.
  - addr_data_a = 2k, addr_data_b = 2k+1.
  - addr_weight_a = n*IN_LEN + 2k, addr_weight_b = n*IN_LEN + 2k + 1.
  - From the second RUN cycle on, acc += pA + pB, with pA = data_a*weight_a and pB = data_b*weight_b (signed full products, sign-extended to ACC_W).
  - On k = P-1: re_bias = 1 and addr_bias = n, then -> LAST.
- LAST (1 cycle):
  - All re low.
  - Accumulate the final pair; capture rdata_bias into bias_q.
  - -> FINISH.
- FINISH (1 cycle):
  - out_data <= sat_DWIDTH((acc >>> FRAC) + sext(bias_q)), with an arithmetic shift and the sum computed at ACC_W+1 bits.
  - Saturation limits are 2^(DWIDTH-1)-1 and -2^(DWIDTH-1).
  - out_index <= n, out_valid <= 1, -> OUT.
- OUT:
  - out_data, out_index and out_valid are held stable and no reads are issued while out_ready = 0.
  - On out_valid && out_ready: out_valid <= 0.
  - If n = OUT-1: done <= 1 for one cycle, n <= 0, -> IDLE.
  - Else: n <= n+1, k <= 0, acc <= 0, -> RUN.
- Latency: out_valid rises P+3 cycles after start is sampled, then P+3 cycles after each handshake.
- Outside RUN, the address outputs hold their last value. re signals are low in every state except as stated above.
- busy is registered: it rises the cycle after start and falls the cycle done is high.
- No accumulator overflow detection. ACC_W must cover IN_LEN products; this is the integrator's responsibility.

Test Plan:
1. Basic pass. Config: IN_LEN=4, OUT=2, FRAC=0, out_ready tied 1. Data [1,2,3,4], weights row0 [1,1,1,1], row1 [1,-1,2,0], bias [5,-3] -> out_data 15 (index 0), then 2 (index 1), then done pulse, then busy low.
2. Timing. Same setup, start sampled at cycle 0 -> re high in cycles 1–2 with data addresses (0,1),(2,3) and weight addresses (0,1),(2,3); re_bias in cycle 2 at address 0; out_valid high at cycle 5; second neuron weight addresses (4,5),(6,7).
3. Saturation. All data and weights 0x7FFF, bias 0x7FFF, FRAC=0 -> out_data 0x7FFF. All data 0x8000, weights 0x7FFF -> out_data 0x8000.
4. Backpressure. out_ready low for 5 cycles after the first out_valid -> out_data and out_index stable, all re low, addresses unchanged. out_ready high -> second neuron reads start the next cycle.
5. Start while busy. Pulse start during RUN and during OUT -> no restart; the sequence matches scenario 1 exactly.
6. Reset mid-RUN. nreset low for 1 cycle during neuron 1 -> next cycle all outputs at reset values, busy 0, no done. A fresh start then yields 15 and 2.
